// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment scanner with per-frame snapshot, PWM brightness and selectable polarity.
// Optional leading-zero suppression is enabled by defining SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_driver #(
    parameter int CLOCK_FREQ         = 100000000,
    parameter int DIGITS             = 8,
    parameter int DWELL_US           = 1000,
    parameter int BRIGHT_BITS        = 4,
    parameter int ANODE_ACTIVE_LOW   = 1,
    parameter int CATHODE_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4*DIGITS-1:0]      display,
    input  logic [DIGITS-1:0]        digit_enable,
    input  logic [DIGITS-1:0]        dp_enable,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]        ANODE,
    output logic [7:0]               CATHODE,
    output logic                     frame_done
);

    localparam int DWELL = CLOCK_FREQ / 1000000 * DWELL_US;
    localparam int SLICE = DWELL >> BRIGHT_BITS;
    localparam int SLOTS = 1 << BRIGHT_BITS;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam bit ANODE_LOW = (ANODE_ACTIVE_LOW != 0);
    localparam bit CATH_LOW  = (CATHODE_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] ANODE_OFF   = {DIGITS{ANODE_LOW}};
    localparam logic [7:0]        CATHODE_OFF = {8{CATH_LOW}};

    typedef enum logic {
        LOAD,
        SCAN
    } scanState_e;

    scanState_e               state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [4*DIGITS-1:0]      dispShadow_q;
    logic [DIGITS-1:0]        enShadow_q;
    logic [DIGITS-1:0]        dpShadow_q;
    logic [BRIGHT_BITS-1:0]   brightShadow_q;
    logic [DIGITS-1:0]        anode_q;
    logic [7:0]               cathode_q;
    logic                     frameDone_q;

    logic [DIGITS-1:0]        anode_d;
    logic [7:0]               cathode_d;
    logic [DIGITS-1:0]        lzMask;
    logic [3:0]               nibble;
    logic [DIGITS-1:0]        anodeOn;
    logic [7:0]               segsOn;
    logic                     litNow;
    int                       slotNum;

    function automatic logic [6:0] segFont(input logic [3:0] n);
        case (n)
            4'h0: segFont = 7'h3F;
            4'h1: segFont = 7'h06;
            4'h2: segFont = 7'h5B;
            4'h3: segFont = 7'h4F;
            4'h4: segFont = 7'h66;
            4'h5: segFont = 7'h6D;
            4'h6: segFont = 7'h7D;
            4'h7: segFont = 7'h07;
            4'h8: segFont = 7'h7F;
            4'h9: segFont = 7'h67;
            4'hA: segFont = 7'h77;
            4'hB: segFont = 7'h7C;
            4'hC: segFont = 7'h39;
            4'hD: segFont = 7'h5E;
            4'hE: segFont = 7'h79;
            default: segFont = 7'h71;
        endcase
    endfunction

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    logic lzBlanking;

    // Walk down from the top digit, blanking zeros until a nonzero nibble or a lit dp stops it.
    always_comb begin
        lzMask     = '1;
        lzBlanking = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lzBlanking && (display[4*i +: 4] == 4'h0) && !dp_enable[i]) begin
                lzMask[i] = 1'b0;
            end else begin
                lzBlanking = 1'b0;
            end
        end
    end
`else
    assign lzMask = '1;
`endif

    // Slot saturation keeps a DWELL that is not a multiple of 2**BRIGHT_BITS in the dark last slot.
    always_comb begin
        nibble  = dispShadow_q[{idx_q, 2'b00} +: 4];
        slotNum = int'(cnt_q) / SLICE;
        if (slotNum > SLOTS - 1) begin
            slotNum = SLOTS - 1;
        end
        litNow  = (state_q == SCAN) && (slotNum < int'(brightShadow_q)) && enShadow_q[idx_q];
        anodeOn = '0;
        segsOn  = '0;
        if (litNow) begin
            anodeOn[idx_q] = 1'b1;
            segsOn         = {dpShadow_q[idx_q], segFont(nibble)};
        end
        anode_d   = anodeOn ^ ANODE_OFF;
        cathode_d = segsOn ^ CATHODE_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LOAD;
            idx_q          <= '0;
            cnt_q          <= '0;
            dispShadow_q   <= '0;
            enShadow_q     <= '0;
            dpShadow_q     <= '0;
            brightShadow_q <= '0;
            anode_q        <= ANODE_OFF;
            cathode_q      <= CATHODE_OFF;
            frameDone_q    <= 1'b0;
        end else begin
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
            frameDone_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    dispShadow_q   <= display;
                    enShadow_q     <= digit_enable & lzMask;
                    dpShadow_q     <= dp_enable;
                    brightShadow_q <= brightness;
                    idx_q          <= '0;
                    cnt_q          <= '0;
                    state_q        <= SCAN;
                end
                default: begin
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_W'(DIGITS - 1)) begin
                            state_q     <= LOAD;
                            frameDone_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ANODE      = anode_q;
    assign CATHODE    = cathode_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized bench for sevenseg_scan_driver against a frame-timeline reference model.
// Follows SEVENSEG_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_sevenseg_scan_driver;

    localparam int DIGITS = 4;
    localparam int DWELL  = 16;
    localparam int SLICE  = 4;
    localparam int FRAME  = DIGITS * DWELL + 1;
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] display = 16'h4321;
    logic [3:0]  digitEnable = 4'hF;
    logic [3:0]  dpEnable = 4'h0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frameDone;

    int checks = 0;
    int errors = 0;
    int fdCount = 0;

    // Model: position inside the current frame (0 = LOAD cycle) plus that frame's snapshot.
    int          ph = 0;
    logic [15:0] sDisp = '0;
    logic [3:0]  sEn = '0;
    logic [3:0]  sDp = '0;
    int          sBright = 0;

    sevenseg_scan_driver #(
        .CLOCK_FREQ(1000000),
        .DIGITS(DIGITS),
        .DWELL_US(16),
        .BRIGHT_BITS(2),
        .ANODE_ACTIVE_LOW(1),
        .CATHODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .display(display),
        .digit_enable(digitEnable),
        .dp_enable(dpEnable),
        .brightness(brightness),
        .ANODE(anode),
        .CATHODE(cathode),
        .frame_done(frameDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [3:0] blankMask(input logic [15:0] d, input logic [3:0] p);
        logic [3:0] m;
        m = 4'hF;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (d[i*4 +: 4] != 4'h0 || p[i]) break;
            m[i] = 1'b0;
        end
`else
        if (d == 16'hFFFF && p == 4'hF) m = 4'hF;
`endif
        return m;
    endfunction

    // One clock: predict what the registered outputs show after this edge, then compare.
    task automatic stepCycle();
        logic [3:0] expAn;
        logic [7:0] expCa;
        logic       expFd;
        int         s;
        int         dig;
        int         slot;
        @(posedge clk);
        #1;
        expAn = 4'hF;
        expCa = 8'hFF;
        expFd = 1'b0;
        if (reset) begin
            ph      = 0;
            sDisp   = '0;
            sEn     = '0;
            sDp     = '0;
            sBright = 0;
        end else begin
            expFd = (ph == FRAME - 1);
            if (ph == 0) begin
                sDisp   = display;
                sEn     = digitEnable & blankMask(display, dpEnable);
                sDp     = dpEnable;
                sBright = int'(brightness);
            end else begin
                s    = ph - 1;
                dig  = s / DWELL;
                slot = (s % DWELL) / SLICE;
                if (slot > 3) slot = 3;
                if (slot < sBright && sEn[dig]) begin
                    expAn = ~(4'b0001 << dig);
                    expCa = ~{sDp[dig], FONT[sDisp[dig*4 +: 4]]};
                end
            end
            ph = (ph + 1) % FRAME;
        end
        if (frameDone) fdCount++;
        checkOutput("anode", 32'(anode), 32'(expAn));
        checkOutput("cathode", 32'(cathode), 32'(expCa));
        checkOutput("frameDone", 32'(frameDone), 32'(expFd));
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] en,
                                 input logic [3:0] dp, input logic [1:0] br);
        @(negedge clk);
        display     = d;
        digitEnable = en;
        dpEnable    = dp;
        brightness  = br;
    endtask

    task automatic pulseReset(input int n);
        @(negedge clk);
        reset = 1'b1;
        runCycles(n);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset for three cycles, then two full frames at high brightness.
        runCycles(3);
        @(negedge clk);
        reset   = 1'b0;
        fdCount = 0;
        runCycles(2 * FRAME);
        checkOutput("frameCount", 32'(fdCount), 32'd2);

        applyStimulus(16'h4321, 4'hF, 4'h0, 2'd1);
        runCycles(2 * FRAME);
        applyStimulus(16'h4321, 4'hF, 4'h0, 2'd0);
        runCycles(2 * FRAME);

        // Mid-frame display change must wait for the next LOAD.
        applyStimulus(16'h1111, 4'hF, 4'h0, 2'd3);
        runCycles(FRAME + 25);
        applyStimulus(16'h2222, 4'hF, 4'h0, 2'd3);
        runCycles(2 * FRAME);

        applyStimulus(16'h1111, 4'b0101, 4'b0100, 2'd3);
        runCycles(2 * FRAME);

        // Reset while digit 2 is being scanned.
        for (int k = 0; k < FRAME && !(ph >= 36 && ph <= 44); k++) stepCycle();
        pulseReset(1);
        fdCount = 0;
        runCycles(FRAME);
        checkOutput("frameAfterReset", 32'(fdCount), 32'd1);

        applyStimulus(16'h0050, 4'hF, 4'h0, 2'd3);
        runCycles(2 * FRAME);
        applyStimulus(16'h0000, 4'hF, 4'h0, 2'd3);
        runCycles(2 * FRAME);

        for (int r = 0; r < 60; r++) begin
            applyStimulus(($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                          4'($urandom), 4'($urandom), 2'($urandom));
            if ($urandom_range(0, 9) == 0) pulseReset($urandom_range(1, 2));
            runCycles($urandom_range(5, 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
